// File: rtl/adder_acc_stage.sv
// adder_acc_stage: frame accumulator fed by the adder_mini result register.
// Sums a programmable number of N-bit samples into an (N+CNT_W)-bit total and
// presents it on a valid/ready port, holding it until the consumer accepts.
// Optional feature macro: ADDER_ACC_SIGNED_EN (sign-extend samples into acc).
module adder_acc_stage #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CNT_W-1:0]   len,
  input  logic               flush,
  output logic [N+CNT_W-1:0] out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state;
  logic [N+CNT_W-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_q;

  logic               xfer;
  logic [N+CNT_W-1:0] ext_data;
  logic [CNT_W-1:0]   len_eff;
  logic [CNT_W-1:0]   cnt_next;

  // Handshake decode from registered state only, plus per-sample helpers.
  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
    xfer      = in_valid && in_ready;
`ifdef ADDER_ACC_SIGNED_EN
    ext_data  = {{CNT_W{in_data[N-1]}}, in_data};
`else
    ext_data  = {{CNT_W{1'b0}}, in_data};
`endif
    len_eff   = (len == '0) ? CNT_ONE : len;
    cnt_next  = cnt + CNT_ONE;
  end

  // Frame state machine; flush overrides transfers and output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            len_q <= len_eff;
            acc   <= ext_data;
            cnt   <= CNT_ONE;
            state <= (len_eff == CNT_ONE) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc <= acc + ext_data;
            cnt <= cnt_next;
            if (cnt_next == len_q) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The accumulator registers double as the output registers.
  always_comb begin
    out_data  = acc;
    out_count = cnt;
  end

endmodule

// File: tb/tb_adder_acc_stage.sv
// tb_adder_acc_stage: scoreboard bench for adder_acc_stage with directed
// corner cases and randomized frames checked against an arithmetic model.
module tb_adder_acc_stage;

  localparam int N     = 32;
  localparam int CNT_W = 8;
  localparam int W     = N + CNT_W;

  typedef struct {
    logic [W-1:0]     data;
    logic [CNT_W-1:0] count;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] len_in;
  logic             flush;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  bit   randReady = 0;

  adder_acc_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .len       (len_in),
    .flush     (flush),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame total is the plain sum of its samples.
  function automatic exp_t frameModel(input logic [N-1:0] s[$], input int lenVal);
    exp_t   e;
    longint sum = 0;
    int     n   = (lenVal == 0) ? 1 : lenVal;
    for (int i = 0; i < n; i++) begin
`ifdef ADDER_ACC_SIGNED_EN
      sum += longint'(int'(s[i]));
`else
      sum += longint'({32'h0, s[i]});
`endif
    end
    e.data  = sum[W-1:0];
    e.count = n[CNT_W-1:0];
    return e;
  endfunction

  // Monitor: pop and compare on every output handshake the DUT honours.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got data=%0h count=%0d, expected none", out_data, out_count);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_count", 64'(out_count), 64'(e.count));
      end
    end
  end

  // Present one sample and return #1 after the edge that accepts it.
  task automatic sendSample(input logic [N-1:0] d);
    bit accepted = 0;
    in_valid = 1;
    in_data  = d;
    for (int c = 0; c < 400 && !accepted; c++) begin
      @(negedge clk);
      accepted = in_ready && !flush;
      @(posedge clk);
      #1;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 0;
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL sample_accept_timeout: got in_ready=0, expected 1 within 400 cycles");
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    if (randReady) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic sendFrame(input int lenVal, input logic [N-1:0] s[$], input bit gaps, input bit wiggleLen);
    len_in = lenVal[CNT_W-1:0];
    foreach (s[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) idleCycle();
      sendSample(s[i]);
      if (wiggleLen) len_in = CNT_W'($urandom);
    end
  endtask

  task automatic drain();
    int c = 0;
    out_ready = 1;
    while (expQ.size() != 0 && c < 600) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_queue_empty", 64'(expQ.size()), 64'd0);
  endtask

  task automatic applyStimulus();
    logic [N-1:0] s[$];
    exp_t         e;
    logic [W-1:0] holdData;

    // Reset state
    rst_n = 0; in_valid = 0; in_data = 0; flush = 0; out_ready = 1; len_in = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1; rst_n = 1;

    // Reset mid-frame, then a fresh frame
    len_in = 4;
    sendSample(10);
    sendSample(20);
    rst_n = 0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid2", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    s = '{32'd5, 32'd6};
    e = frameModel(s, 2);
    check("model_5_6", 64'(e.data), 64'd11);
    expQ.push_back(e);
    sendFrame(2, s, 0, 0);
    drain();

    // Basic frame with a gap, latency checked around the last sample
    s = '{32'd1, 32'd2, 32'd3, 32'd4};
    e = frameModel(s, 4);
    check("model_basic", 64'(e.data), 64'd10);
    expQ.push_back(e);
    len_in = 4;
    sendSample(1);
    sendSample(2);
    idleCycle();
    sendSample(3);
    @(negedge clk);
    check("basic_not_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    sendSample(4);
    @(negedge clk);
    check("basic_latency_valid", 64'(out_valid), 64'd1);
    check("basic_out_data", 64'(out_data), 64'd10);
    check("basic_out_count", 64'(out_count), 64'd4);
    @(posedge clk); #1;
    drain();

    // Backpressure: held output stable, pending sample not consumed
    out_ready = 0;
    s = '{32'd100, 32'd200, 32'd300};
    expQ.push_back(frameModel(s, 3));
    sendFrame(3, s, 0, 0);
    len_in = 1; in_valid = 1; in_data = 77;
    s = '{32'd77};
    expQ.push_back(frameModel(s, 1));
    holdData = 40'd600;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data", 64'(out_data), 64'(holdData));
      check("bp_out_count", 64'(out_count), 64'd3);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_after_hs", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    drain();

    // len edge cases
    s = '{32'd7};
    expQ.push_back(frameModel(s, 0));
    sendFrame(0, s, 0, 0);
    drain();
    s = {};
    for (int i = 0; i < 255; i++) s.push_back(32'hFFFF_FFFF);
    e = frameModel(s, 255);
`ifndef ADDER_ACC_SIGNED_EN
    check("model_len255", 64'(e.data), 64'hFE_FFFF_FF01);
`endif
    expQ.push_back(e);
    sendFrame(255, s, 0, 0);
    drain();

    // flush together with a transfer in ACCUM
    len_in = 4;
    sendSample(1);
    sendSample(2);
    in_valid = 1; in_data = 3; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    check("flush_accum_busy", 64'(busy), 64'd0);
    check("flush_accum_count", 64'(out_count), 64'd0);
    @(posedge clk); #1;

    // flush in HOLD while out_ready is high
    len_in = 1;
    sendSample(50);
    flush = 1; out_ready = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("flush_hold_busy", 64'(busy), 64'd0);
    check("flush_hold_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    s = '{32'd9};
    expQ.push_back(frameModel(s, 1));
    sendFrame(1, s, 0, 0);
    drain();

    // Mixed-sign frame
    s = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd5};
    e = frameModel(s, 3);
`ifdef ADDER_ACC_SIGNED_EN
    check("model_signed", 64'(e.data), 64'd2);
`else
    check("model_unsigned", 64'(e.data), 64'h2_0000_0002);
`endif
    expQ.push_back(e);
    sendFrame(3, s, 0, 0);
    @(negedge clk);
    check("sign_frame_data", 64'(out_data), 64'(e.data));
    @(posedge clk); #1;
    drain();

    // Randomized frames with gaps, random out_ready and mid-frame len changes
    randReady = 1;
    for (int f = 0; f < 40; f++) begin
      int l = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 40) : $urandom_range(0, 6);
      int n = (l == 0) ? 1 : l;
      s = {};
      for (int i = 0; i < n; i++) s.push_back($urandom);
      expQ.push_back(frameModel(s, l));
      sendFrame(l, s, 1, 1);
    end
    randReady = 0;
    drain();
  endtask

  task automatic checkOutput();
    check("final_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_acc_stage.md
# adder_acc_stage

Frame accumulator that sits directly downstream of the `adder_mini` result register. It consumes the registered `N`-bit results one per cycle and sums a programmable number of them into a widened accumulator. It then presents the frame total on a valid/ready output port. Output is held until the consumer accepts it, so the upstream stage sees backpressure through `in_ready`.

## Interface
- `N`, 32: width of each incoming result sample.
- `CNT_W`, 8: width of the frame-length field; a frame holds at most 2^CNT_W − 1 samples.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_data`  input  N  result sample from the upstream `reg_0` register.
- `in_valid`  input  1  `in_data` holds a sample this cycle.
- `in_ready`  output  1  block accepts a sample this cycle; a transfer happens when `in_valid && in_ready`.
- `len`  input  CNT_W  samples per frame; sampled only on the first transfer of a frame; 0 is treated as 1.
- `flush`  input  1  synchronous abort: discard the partial or held frame and return to IDLE.
- `out_data`  output  N+CNT_W  frame total.
- `out_count`  output  CNT_W  number of samples summed into `out_data`.
- `out_valid`  output  1  `out_data` and `out_count` are valid.
- `out_ready`  input  1  consumer accepts the output this cycle.
- `busy`  output  1  a frame is in progress or held (state ≠ IDLE).

## Operation
- The block has three states: IDLE, ACCUM and HOLD.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On a transfer:
    - `len_q` ← (`len`==0 ? 1 : `len`)
    - `acc` ← ext(`in_data`)
    - `cnt` ← 1
  - If `len_q`==1, go to HOLD; otherwise go to ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - On each transfer: `acc` ← `acc` + ext(`in_data`) and `cnt` ← `cnt`+1.
  - When the transfer makes `cnt`==`len_q`, go to HOLD.
  - Idle cycles (`in_valid`=0) leave all state unchanged.
- **HOLD**
  - `in_ready`=0, `out_valid`=1.
  - `out_data`=`acc`, `out_count`=`cnt`; both stay stable until the handshake.
  - On `out_valid && out_ready`, go to IDLE.
- **Arithmetic**
  - `acc` is N+CNT_W bits wide, so a frame cannot overflow.
  - ext() is zero-extension, unless the macro in Configuration is defined.
- **flush**
  - Takes priority over every other event in the same cycle, including a transfer or an output handshake.
  - Next state is IDLE; `acc`, `cnt` and `len_q` are cleared.
  - Any sample presented in the flush cycle is dropped.
- **`len` changes mid-frame** have no effect; the new value applies at the next frame's first transfer.
- **Reset** (asserted at any time, including mid-frame or during HOLD) forces the same result as reset state; no partial output is emitted.

## Timing
- **Reset values:**
  - state=IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `out_data`=0
  - `out_count`=0
  - `busy`=0
- **Latency:** `out_valid` rises in the cycle after the clock edge that accepts the last sample of a frame.
- **Bubble:** one mandatory bubble per frame. `in_ready` is 0 in HOLD and returns to 1 in the cycle after the output handshake.
- **Throughput:**
  - At most one sample per cycle in IDLE/ACCUM.
  - Best-case frame period is `len_q`+1 cycles when `out_ready` is held high.
- **Combinational paths:**
  - `in_ready`, `out_valid` and `busy` are decoded from registered state only.
  - No combinational path from `out_ready` or `in_valid` to any output.
- **Registers:** `out_data` and `out_count` are registered; they are only written when a sample is accepted.

## Configuration
- **`ADDER_ACC_SIGNED_EN`**
  - Defined: ext() sign-extends `in_data` (two's complement) into `acc`, and `out_data` is a signed total.
  - Undefined: ext() zero-extends and `out_data` is unsigned.
  - All handshake, counting and state behaviour is identical in both builds.

## Test plan
- **Reset mid-frame**
  - Stimulus: deassert `rst_n` after 2 of 4 samples, then release.
  - Required: `out_valid`=0, `busy`=0, `in_ready`=1.
  - Then a fresh frame of `len`=2 with 5 and 6 → `out_data`=11.
- **Basic frame with gaps**
  - Stimulus: `len`=4, samples 1, 2, 3, 4 with one idle cycle between 2 and 3.
  - Required: `out_valid` exactly one cycle after the 4th transfer; `out_data`=10, `out_count`=4.
- **Backpressure**
  - Stimulus: `out_ready`=0 for 5 cycles after `out_valid`.
  - Required: output stable throughout, `in_ready`=0, and upstream `in_valid` samples are not consumed.
  - After the handshake, `in_ready`=1 on the next cycle.
- **len edge cases**
  - `len`=0 with sample 7 → `out_data`=7, `out_count`=1.
  - `len`=255 with all samples 0xFFFFFFFF → `out_data`=0xFE_FFFFFF01 (unsigned build), `out_count`=255.
- **flush priority**
  - Stimulus: assert `flush` in the same cycle as a transfer in ACCUM, and separately in HOLD with `out_ready`=1.
  - Required: IDLE next cycle, no output handshake counted.
  - A next frame of `len`=1 with 9 → `out_data`=9.
- **Signed build** (`ADDER_ACC_SIGNED_EN` defined)
  - Stimulus: `len`=3 with samples 0xFFFFFFFF, 0xFFFFFFFE, 5.
  - Required: `out_data`=2.
  - In the unsigned build the same frame → 0x1_FFFFFFFD + 5 = 0x2_00000002.
